// File: rtl/signed_compare_sequencer_if.sv
// Operand/result handshake plus the shared four-bit comparator hookup for
// signed_compare_sequencer. The slave modport is the sequencer side.
interface signed_compare_sequencer_if #(
  parameter int unsigned NIB = 2
);
  logic                 start;
  logic [4*NIB-1:0]     a;
  logic [4*NIB-1:0]     b;
  logic                 busy;
  logic                 done;
  logic [2:0]           HEL;
  logic                 err;
  logic [3:0]           cmp_a;
  logic [3:0]           cmp_b;
  logic                 cmp_en;
  logic [2:0]           cmp_hel;

  modport master (
    output start, a, b, cmp_hel,
    input  busy, done, HEL, err, cmp_a, cmp_b, cmp_en
  );

  modport slave (
    input  start, a, b, cmp_hel,
    output busy, done, HEL, err, cmp_a, cmp_b, cmp_en
  );
endinterface

// File: rtl/signed_compare_sequencer.sv
// Signed N-nibble comparison by time-sharing one external four-bit comparator,
// most significant nibble first, stopping at the first nibble that differs.
module signed_compare_sequencer #(
  parameter int unsigned NIB = 2
) (
  input logic                         clk,
  input logic                         rst,
  signed_compare_sequencer_if.slave   bus
);

  localparam int unsigned W      = 4 * NIB;
  localparam logic [1:0]  IdxTop = 2'(NIB - 1);

  typedef enum logic [0:0] {StIdle, StCmp} state_e;

  state_e         state_q;
  logic [1:0]     idx_q;
  logic [W-1:0]   opa_q;
  logic [W-1:0]   opb_q;
  logic [2:0]     hel_q;
  logic           busy_q;
  logic           done_q;
  logic           err_q;

  // Operands zero-extended to 16 bits so the nibble select never leaves range.
  logic [15:0]    opa_ext;
  logic [15:0]    opb_ext;
  logic [3:0]     sign_flip;

  assign opa_ext = 16'(opa_q);
  assign opb_ext = 16'(opb_q);

  // Inverting bit 3 of the top nibble maps signed order onto unsigned order.
  assign sign_flip = {(idx_q == IdxTop), 3'b000};

  // Comparator drive: purely a function of state, index and captured operands.
  always_comb begin
    bus.cmp_en = 1'b0;
    bus.cmp_a  = 4'h0;
    bus.cmp_b  = 4'h0;
    if (state_q == StCmp) begin
      bus.cmp_en = 1'b1;
      bus.cmp_a  = opa_ext[{idx_q, 2'b00} +: 4] ^ sign_flip;
      bus.cmp_b  = opb_ext[{idx_q, 2'b00} +: 4] ^ sign_flip;
    end
  end

  // Sequencer FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= 2'd0;
      opa_q   <= '0;
      opb_q   <= '0;
      hel_q   <= 3'b000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            opa_q   <= bus.a;
            opb_q   <= bus.b;
            idx_q   <= IdxTop;
            busy_q  <= 1'b1;
            err_q   <= 1'b0;
            state_q <= StCmp;
          end
        end
        StCmp: begin
          case (bus.cmp_hel)
            3'b001, 3'b100: begin
              hel_q   <= bus.cmp_hel;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= StIdle;
            end
            3'b010: begin
              if (idx_q == 2'd0) begin
                hel_q   <= 3'b010;
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= StIdle;
              end else begin
                idx_q <= idx_q - 2'd1;
              end
            end
            default: begin
              // Comparator gave a non-one-hot answer; report no ordering.
              hel_q   <= 3'b000;
              err_q   <= 1'b1;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= StIdle;
            end
          endcase
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.HEL  = hel_q;
  assign bus.err  = err_q;

endmodule

// File: tb/tb_signed_compare_sequencer.sv
// Scoreboard bench: expectations queued at start, checked when done pulses.
module tb_signed_compare_sequencer;

  logic clk;
  logic rst;
  logic force_bad;

  signed_compare_sequencer_if #(.NIB(2)) if2 ();
  signed_compare_sequencer_if #(.NIB(4)) if4 ();

  signed_compare_sequencer #(.NIB(2)) u_dut2 (.clk(clk), .rst(rst), .bus(if2.slave));
  signed_compare_sequencer #(.NIB(4)) u_dut4 (.clk(clk), .rst(rst), .bus(if4.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference four-bit unsigned comparator.
  function automatic logic [2:0] cmp4(input logic [3:0] x, input logic [3:0] y,
                                      input logic en);
    if (!en) return 3'b000;
    if (x < y) return 3'b001;
    if (x == y) return 3'b010;
    return 3'b100;
  endfunction

  assign if2.cmp_hel = force_bad ? 3'b011 : cmp4(if2.cmp_a, if2.cmp_b, if2.cmp_en);
  assign if4.cmp_hel = cmp4(if4.cmp_a, if4.cmp_b, if4.cmp_en);

  typedef struct {
    logic [2:0] hel;
    logic       err;
    int         passes;
    int         t0;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Signed reference result and pass count for an nib-nibble compare.
  function automatic void model(input logic [15:0] av, input logic [15:0] bv, input int nib,
                                output logic [2:0] hel, output int passes);
    int w;
    int sa;
    int sbv;
    w   = 4 * nib;
    sa  = int'(av) & ((1 << w) - 1);
    sbv = int'(bv) & ((1 << w) - 1);
    if (av[w-1]) sa  = sa - (1 << w);
    if (bv[w-1]) sbv = sbv - (1 << w);
    hel = (sa < sbv) ? 3'b001 : (sa == sbv) ? 3'b010 : 3'b100;
    passes = nib;
    for (int i = nib - 1; i >= 0; i--) begin
      if (av[4*i +: 4] != bv[4*i +: 4]) begin
        passes = nib - i;
        break;
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Drive one start on the NIB=2 instance and queue its expectation.
  task automatic start_cmp(input logic [7:0] av, input logic [7:0] bv, input bit bad);
    exp_t e;
    model({8'h00, av}, {8'h00, bv}, 2, e.hel, e.passes);
    e.err = 1'b0;
    if (bad) begin
      e.hel    = 3'b000;
      e.err    = 1'b1;
      e.passes = 1;
    end
    e.t0 = cyc + 1;
    sb.push_back(e);
    if2.a     = av;
    if2.b     = bv;
    force_bad = bad;
    if2.start = 1'b1;
    tick();
    if2.start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 16 && if2.busy; i++) tick();
    check_eq("idle_timeout", 32'(if2.busy), 32'd0);
    force_bad = 1'b0;
  endtask

  task automatic run4(input logic [15:0] av, input logic [15:0] bv);
    logic [2:0] eh;
    int         ep;
    int         lat;
    model(av, bv, 4, eh, ep);
    if4.a     = av;
    if4.b     = bv;
    if4.start = 1'b1;
    tick();
    if4.start = 1'b0;
    lat = 0;
    while (if4.done !== 1'b1 && lat < 16) begin
      tick();
      lat++;
    end
    check_eq("n4_hel", 32'(if4.HEL), 32'(eh));
    check_eq("n4_err", 32'(if4.err), 32'd0);
    check_eq("n4_latency", 32'(lat), 32'(ep));
  endtask

  // Monitor: samples just after each rising edge and retires scoreboard entries.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (if2.done === 1'b1) begin
        if (sb.size() == 0) begin
          check_eq("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check_eq("hel", 32'(if2.HEL), 32'(e.hel));
          check_eq("err", 32'(if2.err), 32'(e.err));
          check_eq("latency", 32'(cyc - e.t0), 32'(e.passes));
          check_eq("busy_at_done", 32'(if2.busy), 32'd0);
        end
      end
    end
  end

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    rst = 1'b1;
    force_bad = 1'b0;
    if2.start = 1'b0;
    if2.a = '0;
    if2.b = '0;
    if4.start = 1'b0;
    if4.a = '0;
    if4.b = '0;
    tick();
    tick();
    rst = 1'b0;
    check_eq("rst_busy", 32'(if2.busy), 32'd0);
    check_eq("rst_done", 32'(if2.done), 32'd0);
    check_eq("rst_hel", 32'(if2.HEL), 32'd0);
    check_eq("rst_err", 32'(if2.err), 32'd0);
    check_eq("rst_cmp_en", 32'(if2.cmp_en), 32'd0);
    check_eq("rst_cmp_ab", 32'({if2.cmp_a, if2.cmp_b}), 32'd0);
    tick();

    // 127 vs -128: decided on the top nibble.
    start_cmp(8'h7F, 8'h80, 1'b0);
    check_eq("p1_cmp_a", 32'(if2.cmp_a), 32'hF);
    check_eq("p1_cmp_b", 32'(if2.cmp_b), 32'h0);
    check_eq("p1_cmp_en", 32'(if2.cmp_en), 32'd1);
    check_eq("p1_busy", 32'(if2.busy), 32'd1);
    wait_idle();

    // -1 vs 0.
    start_cmp(8'hFF, 8'h00, 1'b0);
    check_eq("m1_cmp_ab", 32'({if2.cmp_a, if2.cmp_b}), 32'h78);
    wait_idle();

    // 0x35 vs 0x37: equal top nibble, then the low nibble decides.
    start_cmp(8'h35, 8'h37, 1'b0);
    check_eq("p1_nib_ab", 32'({if2.cmp_a, if2.cmp_b}), 32'hBB);
    tick();
    check_eq("p2_nib_ab", 32'({if2.cmp_a, if2.cmp_b}), 32'h57);
    wait_idle();

    start_cmp(8'hA5, 8'hA5, 1'b0);
    wait_idle();

    // Starts during a busy compare are ignored; one held into done is accepted.
    start_cmp(8'h35, 8'h37, 1'b0);
    if2.a = 8'h00;
    if2.b = 8'hFF;
    if2.start = 1'b1;
    tick();
    tick();
    check_eq("ignore_done", 32'(if2.done), 32'd1);
    start_cmp(8'h12, 8'h12, 1'b0);
    wait_idle();

    // Reset in the second CMP cycle aborts with no done pulse.
    start_cmp(8'hA5, 8'hA5, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    void'(sb.pop_back());
    check_eq("abort_busy", 32'(if2.busy), 32'd0);
    check_eq("abort_done", 32'(if2.done), 32'd0);
    check_eq("abort_hel", 32'(if2.HEL), 32'd0);
    check_eq("abort_cmp_en", 32'(if2.cmp_en), 32'd0);
    repeat (4) tick();

    // Non-one-hot comparator answer flags err; next accepted start clears it.
    start_cmp(8'h44, 8'h44, 1'b1);
    wait_idle();
    start_cmp(8'h10, 8'h20, 1'b0);
    check_eq("err_cleared", 32'(if2.err), 32'd0);
    wait_idle();

    // Random pairs, back to back, biased toward shared top nibbles.
    for (int i = 0; i < 24; i++) begin
      ra = 8'($urandom);
      case ($urandom_range(0, 3))
        0: rb = ra;
        1: rb = ra ^ 8'($urandom_range(1, 15));
        2: rb = ra ^ 8'h80;
        default: rb = 8'($urandom);
      endcase
      start_cmp(ra, rb, 1'b0);
      wait_idle();
    end

    tick();
    run4(16'h8000, 16'h8000);
    run4(16'h8000, 16'h7FFF);
    run4(16'h1234, 16'h1235);
    tick();

    check_eq("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/signed_compare_sequencer.md
# signed_compare_sequencer

Multi-cycle controller that performs a signed two's-complement magnitude comparison of two N-nibble operands by time-sharing one four-bit comparator, most significant nibble first, with early termination. It sits between the calculator's operand registers and the shared four-bit comparator. It drives the comparator's operand and enable inputs, samples its one-hot HEL result, and returns a registered signed HEL result with a start/busy/done handshake.

## Interface
- NIB, default 2, operand width in nibbles; legal 1..4; operand width W = 4*NIB.
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a comparison; sampled only in IDLE.
- a  in  W  operand A, two's complement; captured on accepted start.
- b  in  W  operand B, two's complement; captured on accepted start.
- busy  out  1  high from the edge that accepts start until the edge that completes.
- done  out  1  one-cycle pulse on completion.
- HEL  out  3  registered result: [0] a<b, [1] a==b, [2] a>b; held until next completion.
- err  out  1  registered; set if comparator returned a non-one-hot HEL during a pass.
- cmp_a  out  4  nibble to comparator A input.
- cmp_b  out  4  nibble to comparator B input.
- cmp_en  out  1  comparator enable (active-high), high only in CMP.
- cmp_hel  in  3  comparator result, combinational from cmp_a/cmp_b/cmp_en, same encoding as HEL.

## Operation
- States: IDLE, CMP. Nibble index idx, width 2, counts NIB-1 down to 0.
- IDLE: cmp_en=0, cmp_a=cmp_b=0. start=1 latches a, b into opA/opB, sets idx=NIB-1 and busy=1, and clears err. Next state is CMP.
- CMP: cmp_en=1. cmp_a = opA[4*idx+3:4*idx] and cmp_b likewise from opB.
- When idx==NIB-1, bit 3 of both cmp_a and cmp_b is inverted (sign flip). Unsigned order of the flipped MS nibble equals signed order.
- Each CMP edge samples cmp_hel:
  - 001 or 100: HEL<=cmp_hel, done<=1, busy<=0, go IDLE (early exit).
  - 010 with idx==0: HEL<=010, done<=1, busy<=0, go IDLE.
  - 010 with idx>0: idx<=idx-1, stay in CMP.
  - Any other value (000, multi-hot): HEL<=000, err<=1, done<=1, busy<=0, go IDLE.
- start is ignored while busy=1. Operand inputs are don't-care after capture.
- done is high for exactly the one cycle after the completing edge. HEL and err are stable whenever done=1.
- rst=1 at any edge: state=IDLE, idx=0, opA=opB=0, HEL=000, busy=0, done=0, err=0. An in-flight comparison is aborted with no done pulse.
- cmp_a, cmp_b and cmp_en are combinational from state, idx and the operand registers, so they are 0 in reset and IDLE.

## Timing
- Start sampled at edge t0. Pass p (1..NIB) is evaluated in the cycle after edge t0+p-1 and decided at edge t0+p.
- Latency from start to done: p cycles, minimum 1 (MS nibble differs), maximum NIB (equal operands or only the LS nibble differs).
- Back-to-back: a start held high during the done cycle is accepted at that cycle's edge (state is IDLE). Throughput is one comparison per p+1 cycles at minimum.
- No combinational path from start, a or b to any output. The only in-to-out combinational path is cmp_hel to nothing; it is registered only.

## Test plan
- NIB=2, a=8'h7F, b=8'h80 (127 vs -128): cmp_a=F, cmp_b=0 on pass 1. Required: HEL=100, done one cycle after start, busy high for exactly 1 cycle.
- NIB=2, a=8'hFF, b=8'h00 (-1 vs 0): required HEL=001 after 1 pass. Then a=8'h35, b=8'h37: HEL=001 after 2 passes, with cmp_a/cmp_b = B/B then 5/7.
- NIB=2, a=b=8'hA5: required HEL=010, done after 2 cycles, err=0. With NIB=4, a=b=16'h8000: HEL=010 after 4 cycles.
- start pulsed again on cycles 1 and 2 of a 2-pass compare with new operands: ignored. HEL reflects the first operands and exactly one done pulse occurs. A start held during the done cycle begins the next compare.
- rst asserted in the second CMP cycle: next cycle busy=0, done=0, HEL=000, cmp_en=0. No done pulse follows.
- Bench forces cmp_hel=011 in pass 1: required HEL=000, err=1, done pulse. err clears on the next accepted start.
